fifo_flags_amisha: RTL and testbench
====================================

# fifo_flags_amisha

Parametrised synchronous FIFO that succeeds the basic pointer-plus-flag FIFO. It keeps a registered occupancy count and raises almost-full and almost-empty watermarks. Overflow and underflow errors are captured as sticky flags, and a synchronous flush empties the buffer. It sits between a bursty producer and a paced consumer, for example UART or SPI buffering, where the watermarks drive flow control.

## Interface
- B_amisha, 8: data width in bits.
- W_amisha, 4: address width; DEPTH = 2**W_amisha entries.
- AF_TH_amisha, 14: almost_full asserts when count >= AF_TH_amisha.
- AE_TH_amisha, 2: almost_empty asserts when count <= AE_TH_amisha.
- Legal parameter range: 0 <= AE_TH_amisha < AF_TH_amisha <= DEPTH.
- clk_amisha  in  1  single clock; all logic on its rising edge.
- reset_amisha  in  1  asynchronous, active-high reset.
- clr_amisha  in  1  synchronous flush.
- wr_amisha  in  1  write request.
- rd_amisha  in  1  read request.
- w_data_amisha  in  B  write data.
- r_data_amisha  out  B  head-of-queue data (first-word fall-through).
- empty_amisha / full_amisha  out  1  registered status flags.
- almost_empty_amisha / almost_full_amisha  out  1  registered watermarks.
- count_amisha  out  W+1  current occupancy, 0..DEPTH.
- overflow_amisha / underflow_amisha  out  1  sticky error flags.

## Operation
- **Write acceptance:** a write is accepted when wr & ~full_reg & ~clr.
  - An accepted write stores w_data at w_ptr; w_ptr increments mod DEPTH.
- **Read acceptance:** a read is accepted when rd & ~empty_reg & ~clr.
  - An accepted read increments r_ptr mod DEPTH.
- Acceptance depends only on the registered flags, never on the same-cycle opposite operation.
- **Count update:** count_next = count + wr_acc − rd_acc.
  - Both accepted: pointers both advance and count is unchanged.
  - Full with both requested: only the read is accepted; count goes DEPTH → DEPTH−1 and overflow sets.
  - Empty with both requested: only the write is accepted; count goes 0 → 1 and underflow sets.
- **Flag derivation:** all flags are registered and computed from count_next.
  - empty = (count_next == 0), full = (count_next == DEPTH).
  - almost_full = (count_next >= AF_TH), almost_empty = (count_next <= AE_TH).
- **Sticky errors:**
  - overflow sets on wr & full_reg; underflow sets on rd & empty_reg.
  - Both stay set until clr or reset.
  - Rejected operations change no pointer, count or memory contents.
- **Flush:** clr has priority over wr and rd in the same cycle.
  - Both pointers and count go to 0; flags return to their reset values; sticky errors clear.
  - Concurrent wr/rd are dropped and do not set the error flags.
- **Head data:** r_data = mem[r_ptr], combinational from the array.
  - Its value while empty is don't-care and must not be checked.
- **Wrap-around:** pointers wrap naturally at W bits; count disambiguates full from empty.
- **Reset:** asynchronous, with immediate effect.
  - Outputs take: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0; pointers 0.
  - Memory is not reset.
  - A reset asserted mid-burst discards all contents; the first write after deassertion lands at slot 0.

## Timing
- All state updates on the rising edge of clk_amisha; no multicycle paths.
- Write-to-read latency is 1 cycle: a write accepted at edge N into an empty FIFO gives empty=0 and r_data valid after edge N.
- An accepted read at edge N presents the next entry on r_data after edge N.
- Flags, watermarks and count change exactly on the edge where the op is accepted; there is no extra lag.
- overflow/underflow assert on the edge that samples the offending request.

## Structure
- A shared package/header holds:
  - default B/W constants;
  - the derived DEPTH (2**W) as a localparam function;
  - the parameter legality check, issued as an elaboration-time error.
- Sub-module fifo_regfile_amisha: a 2**W × B array with a registered write port (we, waddr, wdata) and an asynchronous read port (raddr → rdata).
- The top module holds the pointers, count, flag and error registers, and the acceptance logic.

## Test plan
Configuration for all scenarios: B=8, W=4, AF_TH=14, AE_TH=2.
- **Fill and drain:** write 0x01..0x10 on 16 consecutive cycles.
  - Watermarks: almost_empty drops when count reaches 3; almost_full rises at count 14; full rises at count 16.
  - Count passes through 1..16.
  - Then read 16 times: data returns 0x01..0x10 in order and empty re-asserts at count 0.
- **Simultaneous read/write:** with count 5, assert wr+rd for 40 cycles.
  - count holds at 5 and data order is preserved.
  - Pointers wrap at least twice with no flag glitch.
- **Overflow:** at full, write 0xAA.
  - overflow=1, count stays 16, and the stored head data is unchanged.
  - Then wr+rd while full: only the read is accepted, count = 15, overflow stays 1.
- **Underflow:** while empty, read.
  - underflow=1, count 0, r_ptr unchanged.
  - Then wr+rd while empty: count = 1, r_data equals the written word.
- **Flush:** with count 9, overflow set and wr asserted, pulse clr for one cycle.
  - Next cycle: count 0, empty 1, almost_empty 1, overflow 0.
  - The next write of 0x5C appears on r_data one cycle later.
- **Asynchronous reset:** assert reset_amisha mid-cycle during a burst at count 7.
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - After deassertion, the FIFO operates normally from slot 0.

Source files
------------

// File: rtl/fifo_flags_amisha_pkg.sv
// Shared constants and elaboration helpers for the flagged synchronous FIFO.
// Holds default widths, the depth derivation and the parameter legality rule.
package fifo_flags_amisha_pkg;

  localparam int B_DEF     = 8;
  localparam int W_DEF     = 4;
  localparam int AF_TH_DEF = 14;
  localparam int AE_TH_DEF = 2;

  function automatic int depth_f(input int w);
    return 1 << w;
  endfunction

  function automatic bit params_ok(input int w, input int af_th, input int ae_th);
    return (ae_th >= 0) && (ae_th < af_th) && (af_th <= depth_f(w));
  endfunction

endpackage

// File: rtl/fifo_flags_amisha_regfile.sv
// Storage array for the FIFO: one registered write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_regfile_amisha #(
  parameter int B_amisha = 8,
  parameter int W_amisha = 4
) (
  input  logic                clk_amisha,
  input  logic                i_we,
  input  logic [W_amisha-1:0] i_waddr,
  input  logic [B_amisha-1:0] i_wdata,
  input  logic [W_amisha-1:0] i_raddr,
  output logic [B_amisha-1:0] o_rdata
);

  logic [B_amisha-1:0] r_mem [2**W_amisha];

  always_ff @(posedge clk_amisha) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flags_amisha.sv
// Synchronous FIFO with registered count, watermarks, sticky overflow/underflow
// and a synchronous flush. Head data is first-word fall-through.
module fifo_flags_amisha
  import fifo_flags_amisha_pkg::*;
#(
  parameter int B_amisha     = B_DEF,
  parameter int W_amisha     = W_DEF,
  parameter int AF_TH_amisha = AF_TH_DEF,
  parameter int AE_TH_amisha = AE_TH_DEF
) (
  input  logic                clk_amisha,
  input  logic                reset_amisha,
  input  logic                clr_amisha,
  input  logic                wr_amisha,
  input  logic                rd_amisha,
  input  logic [B_amisha-1:0] w_data_amisha,
  output logic [B_amisha-1:0] r_data_amisha,
  output logic                empty_amisha,
  output logic                full_amisha,
  output logic                almost_empty_amisha,
  output logic                almost_full_amisha,
  output logic [W_amisha:0]   count_amisha,
  output logic                overflow_amisha,
  output logic                underflow_amisha
);

  localparam int DEPTH = depth_f(W_amisha);
  localparam logic [W_amisha:0] DEPTH_C = DEPTH[W_amisha:0];
  localparam logic [W_amisha:0] AF_C    = AF_TH_amisha[W_amisha:0];
  localparam logic [W_amisha:0] AE_C    = AE_TH_amisha[W_amisha:0];

  generate
    if (!params_ok(W_amisha, AF_TH_amisha, AE_TH_amisha)) begin : g_bad_params
      $error("fifo_flags_amisha: need 0 <= AE_TH < AF_TH <= 2**W");
    end
  endgenerate

  logic [W_amisha-1:0] r_wptr;
  logic [W_amisha-1:0] r_rptr;
  logic [W_amisha:0]   r_count;
  logic                r_empty;
  logic                r_full;
  logic                r_ae;
  logic                r_af;
  logic                r_ovf;
  logic                r_unf;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [W_amisha:0]   w_count_next;

  // Request/accept: wr (rd) is taken only when the registered full (empty) flag
  // is clear and no flush is pending; the opposite same-cycle op never matters.
  assign w_wr_acc = wr_amisha & ~r_full  & ~clr_amisha;
  assign w_rd_acc = rd_amisha & ~r_empty & ~clr_amisha;

  assign w_count_next = r_count + {{W_amisha{1'b0}}, w_wr_acc}
                                - {{W_amisha{1'b0}}, w_rd_acc};

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr_amisha) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH_C);
      r_ae    <= (w_count_next <= AE_C);
      r_af    <= (w_count_next >= AF_C);
      if (wr_amisha & r_full)  r_ovf <= 1'b1;
      if (rd_amisha & r_empty) r_unf <= 1'b1;
    end
  end

  fifo_regfile_amisha #(
    .B_amisha (B_amisha),
    .W_amisha (W_amisha)
  ) u_regfile (
    .clk_amisha (clk_amisha),
    .i_we       (w_wr_acc),
    .i_waddr    (r_wptr),
    .i_wdata    (w_data_amisha),
    .i_raddr    (r_rptr),
    .o_rdata    (r_data_amisha)
  );

  assign empty_amisha        = r_empty;
  assign full_amisha         = r_full;
  assign almost_empty_amisha = r_ae;
  assign almost_full_amisha  = r_af;
  assign count_amisha        = r_count;
  assign overflow_amisha     = r_ovf;
  assign underflow_amisha    = r_unf;

endmodule

// File: tb/tb_fifo_flags_amisha.sv
// Directed bench for fifo_flags_amisha: fill/drain, wrap, overflow, underflow,
// flush and asynchronous reset, with a data queue tracking expected head words.
module tb_fifo_flags_amisha;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       wr;
  logic       rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       ae;
  logic       af;
  logic [4:0] count;
  logic       ovf;
  logic       unf;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_flags_amisha #(
    .B_amisha     (8),
    .W_amisha     (4),
    .AF_TH_amisha (14),
    .AE_TH_amisha (2)
  ) dut (
    .clk_amisha          (clk),
    .reset_amisha        (reset),
    .clr_amisha          (clr),
    .wr_amisha           (wr),
    .rd_amisha           (rd),
    .w_data_amisha       (w_data),
    .r_data_amisha       (r_data),
    .empty_amisha        (empty),
    .full_amisha         (full),
    .almost_empty_amisha (ae),
    .almost_full_amisha  (af),
    .count_amisha        (count),
    .overflow_amisha     (ovf),
    .underflow_amisha    (unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input bit e, input bit f,
                           input bit a_e, input bit a_f, input bit o, input bit u);
    chk({tag, ".count"}, count, cnt);
    chk({tag, ".empty"}, empty, e);
    chk({tag, ".full"},  full,  f);
    chk({tag, ".ae"},    ae,    a_e);
    chk({tag, ".af"},    af,    a_f);
    chk({tag, ".ovf"},   ovf,   o);
    chk({tag, ".unf"},   unf,   u);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    #1;
    chk_state("reset", 0, 1, 0, 1, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_state("post_reset", 0, 1, 0, 1, 0, 0, 0);

    // Fill 0x01..0x10; watermarks follow the count
    for (int k = 1; k <= 16; k++) begin
      wr = 1'b1; w_data = 8'(k);
      tick();
      chk_state($sformatf("fill%0d", k), k, 0, (k == 16), (k <= 2), (k >= 14), 0, 0);
      chk($sformatf("fill%0d.head", k), r_data, 8'h01);
    end
    wr = 1'b0;

    // Overflow: rejected write of 0xAA leaves contents alone
    wr = 1'b1; w_data = 8'hAA;
    tick();
    wr = 1'b0;
    chk_state("ovf", 16, 0, 1, 0, 1, 1, 0);
    chk("ovf.head", r_data, 8'h01);

    // wr+rd at full: only the read is taken
    wr = 1'b1; rd = 1'b1; w_data = 8'hBB;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk_state("full_wr_rd", 15, 0, 0, 0, 1, 1, 0);
    chk("full_wr_rd.head", r_data, 8'h02);

    // Drain the remaining 0x02..0x10
    for (int k = 2; k <= 16; k++) begin
      chk($sformatf("drain%0d.head", k), r_data, 8'(k));
      rd = 1'b1;
      tick();
      chk_state($sformatf("drain%0d", k), 16 - k, (k == 16), 0, (16 - k <= 2), (16 - k >= 14), 1, 0);
    end
    rd = 1'b0;

    // Underflow, then wr+rd while empty
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_state("unf", 0, 1, 0, 1, 0, 1, 1);
    wr = 1'b1; rd = 1'b1; w_data = 8'h3C;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk_state("empty_wr_rd", 1, 0, 0, 1, 0, 1, 1);
    chk("empty_wr_rd.head", r_data, 8'h3C);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_state("clr1", 0, 1, 0, 1, 0, 0, 0);

    // Count 5, then 40 cycles of simultaneous wr+rd
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'h20 + 8'(i);
      exp_q.push_back(w_data);
      tick();
    end
    wr = 1'b0;
    chk_state("pre_sim", 5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      wr = 1'b1; rd = 1'b1; w_data = 8'h25 + 8'(i);
      tick();
      exp_q.push_back(w_data);
      void'(exp_q.pop_front());
      chk($sformatf("sim%0d.count", i), count, 5);
      chk($sformatf("sim%0d.head", i), r_data, exp_q[0]);
      chk($sformatf("sim%0d.flags", i), {empty, full, ae, af}, 4'b0000);
    end
    wr = 1'b0; rd = 1'b0;

    // Fill to full, overflow, then read down to 9
    for (int i = 0; i < 11; i++) begin
      wr = 1'b1; w_data = 8'h80 + 8'(i);
      exp_q.push_back(w_data);
      tick();
    end
    chk_state("refill", 16, 0, 1, 0, 1, 0, 0);
    w_data = 8'hEE;
    tick();
    wr = 1'b0;
    chk_state("ovf2", 16, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rd9_%0d.head", i), r_data, exp_q[0]);
      rd = 1'b1;
      tick();
      void'(exp_q.pop_front());
    end
    rd = 1'b0;
    chk_state("at9", 9, 0, 0, 0, 0, 1, 0);
    chk("at9.head", r_data, exp_q[0]);

    // Flush with a concurrent write that must be dropped
    clr = 1'b1; wr = 1'b1; w_data = 8'h77;
    tick();
    clr = 1'b0; wr = 1'b0;
    exp_q.delete();
    chk_state("flush", 0, 1, 0, 1, 0, 0, 0);
    wr = 1'b1; w_data = 8'h5C;
    tick();
    wr = 1'b0;
    chk_state("flush_wr", 1, 0, 0, 1, 0, 0, 0);
    chk("flush_wr.head", r_data, 8'h5C);

    // Asynchronous reset in the middle of a burst at count 7
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; w_data = 8'h60 + 8'(i);
      tick();
    end
    chk_state("pre_rst", 7, 0, 0, 0, 0, 0, 0);
    w_data = 8'h67;
    #2;
    reset = 1'b1;
    #1;
    chk_state("async_rst", 0, 1, 0, 1, 0, 0, 0);
    wr = 1'b0;
    tick();
    chk_state("held_rst", 0, 1, 0, 1, 0, 0, 0);
    #3;
    reset = 1'b0;
    wr = 1'b1; w_data = 8'hE7;
    tick();
    wr = 1'b0;
    chk_state("after_rst", 1, 0, 0, 1, 0, 0, 0);
    chk("after_rst.head", r_data, 8'hE7);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_state("after_rst_rd", 0, 1, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
